// File: rtl/unified_mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state type, grant encoding and counter widths for unified_mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam int LAT_W = 3;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// mem_arb_if: fetch, data and memory-macro signals of the unified memory arbiter
interface mem_arb_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic if_valid;
  logic if_stall;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic d_valid;
  logic d_stall;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter_lat_counter.sv
// arb_lat_counter: loadable latency down-counter with zero flag
module arb_lat_counter import mem_arb_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [LAT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one single-port memory shared by fetch and data, data first with a fetch starvation limit.
// Define ARB_PERF_CNT_EN to build the fetch-stall and data-grant performance counters.
module unified_mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_arb_if.slave    bus,
  output logic [31:0] perf_if_stall_cnt,
  output logic [31:0] perf_d_grant_cnt
);
  arb_state_t state, state_nxt;
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic fetch_starved, grant_d, grant_i, grant, lat_zero, resp;
  assign fetch_starved = bus.if_req && starve_cnt == STARVE_W'(STARVE_MAX);
  assign grant_d = state == IDLE && bus.d_req && !fetch_starved;
  assign grant_i = state == IDLE && bus.if_req && !grant_d;
  assign grant = grant_d ? GRANT_D : GRANT_I;
  assign resp = state != IDLE && lat_zero;
  arb_lat_counter u_lat (
    .clk(clk),
    .rst(rst),
    .load(grant_d || grant_i),
    .load_val(LAT_W'(MEM_LAT - 1)),
    .dec(state != IDLE),
    .zero(lat_zero)
  );
  always_ff @(posedge clk) begin
    state <= !rst ? IDLE : state_nxt;
    starve_cnt <= !rst ? '0 : starve_nxt;
  end
  // Outputs are forced low while reset is held so nothing leaks before the first edge.
  always_comb begin
    state_nxt = (grant_d || grant_i) ? (grant == GRANT_D ? BUSY_D : BUSY_I) : resp ? IDLE : state;
    starve_nxt = grant_i ? '0 : !grant_d ? starve_cnt : !bus.if_req ? '0 :
                 starve_cnt == STARVE_W'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
    bus.mem_req = rst && (grant_d || grant_i);
    bus.mem_we = rst && grant_d && bus.d_we;
    bus.mem_addr = !rst ? '0 : grant_d ? bus.d_addr : bus.if_addr;
    bus.mem_wdata = rst ? bus.d_wdata : '0;
    bus.if_valid = rst && resp && state == BUSY_I;
    bus.d_valid = rst && resp && state == BUSY_D;
    bus.if_rdata = rst ? bus.mem_rdata : '0;
    bus.d_rdata = rst ? bus.mem_rdata : '0;
    bus.if_stall = rst && bus.if_req && !bus.if_valid;
    bus.d_stall = rst && bus.d_req && !bus.d_valid;
  end
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    perf_if_stall_cnt <= !rst ? '0 : perf_if_stall_cnt + 32'(bus.if_stall);
    perf_d_grant_cnt <= !rst ? '0 : perf_d_grant_cnt + 32'(grant_d);
  end
`else
  assign perf_if_stall_cnt = '0;
  assign perf_d_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench with a transaction-level arbitration and memory model
module tb_unified_mem_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 2;
  typedef struct {bit is_d; bit we; logic [31:0] data; int due;} resp_t;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] perf_if_stall_cnt, perf_d_grant_cnt;
  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .perf_if_stall_cnt(perf_if_stall_cnt),
    .perf_d_grant_cnt(perf_d_grant_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  int cyc = 0, starve = 0, i_cnt = 0, d_cnt = 0;
  logic [31:0] m_stall = 0, m_dg = 0, last_d = 0;
  logic [31:0] mem [int];
  resp_t q[$];
  bit glog[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic fail_msg(string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask
  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(int'(a >> 2)) ? mem[int'(a >> 2)] : a ^ 32'hA5A5_0000;
  endfunction
  // Memory device, reference arbiter and monitor: samples mid-cycle, then sets mem_rdata for the next cycle.
  always @(negedge clk) begin
    bit idle, exp_issue, exp_d;
    resp_t r;
    cyc++;
    if (!rst) begin
      chk("rst_ctrl", {bus.mem_req, bus.mem_we, bus.if_valid, bus.if_stall, bus.d_valid, bus.d_stall}, 0);
      chk("rst_data", |{bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata}, 0);
      q.delete();
      starve = 0;
      m_stall = 0;
      m_dg = 0;
      bus.mem_rdata = $urandom;
    end else begin
      idle = q.size() == 0;
`ifdef ARB_PERF_CNT_EN
      chk("perf_if_stall", perf_if_stall_cnt, m_stall);
      chk("perf_d_grant", perf_d_grant_cnt, m_dg);
`else
      chk("perf_if_stall_off", perf_if_stall_cnt, 0);
      chk("perf_d_grant_off", perf_d_grant_cnt, 0);
`endif
      if (bus.if_valid || bus.d_valid) begin
        if (q.size() == 0) fail_msg("spurious_valid");
        else begin
          r = q.pop_front();
          chk("valid_cycle", cyc, r.due);
          chk("valid_kind", {bus.if_valid, bus.d_valid}, r.is_d ? 2'b01 : 2'b10);
          if (!r.we) chk(r.is_d ? "d_rdata" : "if_rdata", r.is_d ? bus.d_rdata : bus.if_rdata, r.data);
        end
        if (bus.d_valid) begin
          d_cnt++;
          last_d = bus.d_rdata;
        end
        if (bus.if_valid) i_cnt++;
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        fail_msg("missing_valid");
        void'(q.pop_front());
      end
      chk("if_stall", bus.if_stall, bus.if_req & ~bus.if_valid);
      chk("d_stall", bus.d_stall, bus.d_req & ~bus.d_valid);
      m_stall += 32'(bus.if_req & ~bus.if_valid);
      exp_issue = idle && (bus.if_req || bus.d_req);
      exp_d = bus.d_req && !(bus.if_req && starve >= SMAX);
      chk("mem_req", bus.mem_req, exp_issue);
      if (exp_issue && bus.mem_req) begin
        chk("mem_addr", bus.mem_addr, exp_d ? bus.d_addr : bus.if_addr);
        chk("mem_we", bus.mem_we, exp_d && bus.d_we);
        if (exp_d && bus.d_we) begin
          chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
          mem[int'(bus.mem_addr >> 2)] = bus.mem_wdata;
        end
        r.is_d = exp_d;
        r.we = exp_d && bus.d_we;
        r.data = rd(bus.mem_addr);
        r.due = cyc + LAT;
        q.push_back(r);
        glog.push_back(exp_d);
        starve = (exp_d && bus.if_req) ? starve + 1 : 0;
        if (exp_d) m_dg++;
      end else chk("mem_we_quiet", bus.mem_we, 0);
      bus.mem_rdata = (q.size() != 0 && q[0].due == cyc + 1) ? q[0].data : $urandom;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(int budget);
    int i_seen = i_cnt, d_seen = d_cnt;
    for (int n = 0; n < budget && (bus.if_req || bus.d_req); n++) begin
      tick();
      if (i_cnt != i_seen) bus.if_req = 1'b0;
      if (d_cnt != d_seen) bus.d_req = 1'b0;
    end
    if (bus.if_req || bus.d_req) begin
      fail_msg("request_timeout");
      bus.if_req = 1'b0;
      bus.d_req = 1'b0;
    end
  endtask
  task automatic dreq(bit we, logic [31:0] a, logic [31:0] wd);
    bus.d_req = 1'b1;
    bus.d_we = we;
    bus.d_addr = a;
    bus.d_wdata = wd;
  endtask
  initial begin
    int g0, n, i_seen, d_seen;
    logic [31:0] dg0;
    logic [5:0] ord;
    mem[1] = 32'h0000_2083;
    mem[3] = 32'h0000_0011;
    rst = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h4;
    dreq(1'b0, 32'h0, 32'h0);
    bus.d_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    run(20);
    g0 = glog.size();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h4;
    dreq(1'b0, 32'hC, 32'h0);
    run(30);
    chk("both_d_rdata", last_d, 32'h11);
    chk("both_order", {glog[g0], glog[g0+1]}, 2'b10);
    g0 = glog.size();
    dg0 = perf_d_grant_cnt;
    bus.if_req = 1'b1;
    dreq(1'b0, 32'h8, 32'h0);
    for (n = 0; n < 60 && glog.size() < g0 + 6; n++) tick();
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (LAT + 2) tick();
    if (glog.size() < g0 + 6) fail_msg("starve_timeout");
    else begin
      ord = '0;
      for (int i = 0; i < 6; i++) ord = {ord[4:0], glog[g0+i]};
      chk("starve_order", ord, 6'b110110);
    end
`ifdef ARB_PERF_CNT_EN
    chk("starve_perf_d", perf_d_grant_cnt - dg0, 4);
`endif
    dreq(1'b1, 32'h10, 32'hDEAD_BEEF);
    run(20);
    dreq(1'b0, 32'h10, 32'h0);
    run(20);
    chk("store_load", last_d, 32'hDEAD_BEEF);
    d_seen = d_cnt;
    dreq(1'b0, 32'hC, 32'h0);
    tick();
    rst = 1'b0;
    bus.d_req = 1'b0;
    tick();
    rst = 1'b1;
    repeat (LAT + 3) tick();
    chk("rst_busy_no_valid", d_cnt - d_seen, 0);
    i_seen = i_cnt;
    d_seen = d_cnt;
    for (n = 0; n < 800; n++) begin
      tick();
      if (i_cnt != i_seen) begin
        i_seen = i_cnt;
        bus.if_req = 1'b0;
      end
      if (d_cnt != d_seen) begin
        d_seen = d_cnt;
        bus.d_req = 1'b0;
      end
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!bus.d_req && $urandom_range(0, 1) == 0)
        dreq(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (LAT + 3) tick();
    chk("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
